// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - Round-robin select sequencer driving the s1/s2 selects of a 1-bit 4:1 mux
//
// Optional feature macro: MUXSEQ_LOCK_EN (adds the lock input; when absent lock behaves as 0).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[3:0]   per-channel request (0=a, 1=b, 2=c, 3=d)
//   out_ready  consumer accepts the current beat
//   lock       (MUXSEQ_LOCK_EN only) hold the current grant past its dwell
//   s1, s2     registered mux selects, {s1,s2} = granted index
//   grant[3:0] registered one-hot grant, 0 when idle
//   sel_valid  registered, high while a grant is active
//   done       combinational, high on the final accepted beat of a grant
module mux_sel_sequencer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       out_ready,
`ifdef MUXSEQ_LOCK_EN
    input  logic       lock,
`endif
    output logic       s1,
    output logic       s2,
    output logic [3:0] grant,
    output logic       sel_valid,
    output logic       done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state, state_nxt;
    logic [1:0]        ptr, ptr_nxt;
    logic [1:0]        idx_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [3:0]        grant_nxt;
    logic              valid_nxt;
    logic              lock_i;
    logic [1:0]        cur_idx;
    logic [1:0]        search_ptr;
    logic [1:0]        pick;
    logic              beat, at_last, early, release_now;

`ifdef MUXSEQ_LOCK_EN
    assign lock_i = lock;
`else
    assign lock_i = 1'b0;
`endif

    assign cur_idx = {s1, s2};

    // First set request searching upward from p+1 with wrap; channel p is checked last.
    // Iterating from the farthest offset down lets the nearest hit overwrite earlier ones.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] c;
        rr_pick = p;
        for (int k = 4; k >= 1; k--) begin
            c = p + 2'(k);
            if (r[c]) rr_pick = c;
        end
    endfunction

    assign beat        = sel_valid & out_ready;
    assign at_last     = (cnt == LAST);
    assign done        = beat & at_last & ~lock_i;
    assign early       = sel_valid & ~req[cur_idx];
    assign release_now = done | early;

    // On a release the pointer moves to the channel being released, and the
    // re-grant search must already see that new pointer.
    assign search_ptr = (state == GRANT) ? cur_idx : ptr;
    assign pick       = rr_pick(req, search_ptr);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = cur_idx;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        valid_nxt = sel_valid;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick;
                    grant_nxt = 4'b0001 << pick;
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_nxt = cur_idx;
                    cnt_nxt = '0;
                    if (|req) begin
                        idx_nxt   = pick;
                        grant_nxt = 4'b0001 << pick;
                    end else begin
                        // selects keep their last value while idle
                        state_nxt = IDLE;
                        grant_nxt = 4'b0000;
                        valid_nxt = 1'b0;
                    end
                end else if (beat && !at_last) begin
                    // saturates at LAST while lock suppresses the release
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd3;
            cnt       <= '0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            grant     <= 4'b0000;
            sel_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            s1        <= idx_nxt[1];
            s2        <= idx_nxt[0];
            grant     <= grant_nxt;
            sel_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - Self-checking bench for mux_sel_sequencer
module tb_mux_sel_sequencer;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;
    logic       lock;
    logic       s1, s2, sel_valid, done;
    logic [3:0] grant;

    mux_sel_sequencer #(.DWELL(DWELL), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
`ifdef MUXSEQ_LOCK_EN
        .lock      (lock),
`endif
        .s1        (s1),
        .s2        (s2),
        .grant     (grant),
        .sel_valid (sel_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: which channel holds the grant, how many beats it has had,
    // and who was released last.
    bit   m_active;
    int   m_idx;
    int   m_beats;
    int   m_ptr;
    logic got_done, want_done;

    function automatic int rr_search(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] exp_grant();
        return m_active ? 4'(1 << m_idx) : 4'b0000;
    endfunction

    task automatic model_reset();
        m_active = 0; m_idx = 0; m_beats = 0; m_ptr = 3;
    endtask

    task automatic model_edge();
        bit fin, early;
        if (!m_active) begin
            if (req != 4'b0000) begin
                m_idx = rr_search(req, m_ptr); m_active = 1; m_beats = 0;
            end
        end else begin
            fin   = out_ready && (m_beats == DWELL - 1) && !lock;
            early = !req[m_idx];
            if (fin || early) begin
                m_ptr = m_idx; m_beats = 0;
                if (req != 4'b0000) m_idx = rr_search(req, m_ptr);
                else m_active = 0;
            end else if (out_ready && m_beats < DWELL - 1) begin
                m_beats++;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input logic [3:0] r, input logic rdy);
        req = r; out_ready = rdy;
        #1;
        got_done  = done;
        want_done = m_active && rdy && (m_beats == DWELL - 1) && !lock;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0; lock = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({s1, s2, grant, sel_valid, done} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_state: got s=%b%b grant=%b valid=%b done=%b want all 0", s1, s2, grant, sel_valid, done);
        end
    endtask

    task automatic test_single();
        do_reset();
        tick(4'b0001, 1'b1);
        n_cmp++;
        if ({s1, s2, grant, sel_valid} !== 7'b00_0001_1) begin
            n_fail++;
            $display("FAIL single_first: got s=%b%b grant=%b valid=%b want 00 0001 1", s1, s2, grant, sel_valid);
        end
        for (int b = 0; b < 4; b++) begin
            tick((b == 3) ? 4'b0000 : 4'b0001, 1'b1);
            n_cmp++;
            if (got_done !== (b == 3) || got_done !== want_done) begin
                n_fail++;
                $display("FAIL single_done beat %0d: got %b want %b", b, got_done, (b == 3));
            end
        end
        n_cmp++;
        if ({grant, sel_valid} !== 5'b0 || {s1, s2} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_idle: got s=%b%b grant=%b valid=%b want 00 0000 0", s1, s2, grant, sel_valid);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        tick(4'b1111, 1'b1);
        for (int k = 0; k <= 16; k++) begin
            n_cmp++;
            if ({s1, s2} !== 2'((k / 4) % 4) || grant !== 4'(1 << ((k / 4) % 4)) || sel_valid !== 1'b1
                || {s1, s2, grant, sel_valid} !== {2'(m_idx), exp_grant(), m_active}) begin
                n_fail++;
                $display("FAIL rotation cycle %0d: got s=%b%b grant=%b valid=%b want idx %0d", k, s1, s2, grant, sel_valid, (k / 4) % 4);
            end
            if (k < 16) tick(4'b1111, 1'b1);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        tick(4'b0010, 1'b1);
        for (int c = 0; c < 8; c++) begin
            tick(4'b0010, (c % 2) == 0);
            n_cmp++;
            if (got_done !== (c == 6) || grant !== 4'b0010 || {s1, s2} !== 2'b01 || sel_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d: got done=%b grant=%b s=%b%b want done=%b grant=0010 s=01", c, got_done, grant, s1, s2, (c == 6));
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        tick(4'b0101, 1'b1);
        tick(4'b0101, 1'b1);
        tick(4'b0101, 1'b1);
        tick(4'b0100, 1'b1);
        n_cmp++;
        if ({s1, s2, grant, sel_valid} !== 7'b10_0100_1 || got_done !== 1'b0) begin
            n_fail++;
            $display("FAIL early_release: got s=%b%b grant=%b valid=%b done=%b want 10 0100 1 0", s1, s2, grant, sel_valid, got_done);
        end
        for (int b = 0; b < 4; b++) begin
            tick(4'b0100, 1'b1);
            n_cmp++;
            if (got_done !== (b == 3)) begin
                n_fail++;
                $display("FAIL early_fresh_count beat %0d: got done=%b want %b", b, got_done, (b == 3));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(4'b0001, 1'b1);
        tick(4'b0011, 1'b1);
        tick(4'b0110, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({s1, s2, grant, sel_valid, done} !== 8'b0) begin
            n_fail++;
            $display("FAIL async_reset: got s=%b%b grant=%b valid=%b done=%b want all 0", s1, s2, grant, sel_valid, done);
        end
        model_reset();
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick(4'b1000, 1'b1);
        n_cmp++;
        if ({s1, s2, grant, sel_valid} !== 7'b11_1000_1) begin
            n_fail++;
            $display("FAIL async_reset_regrant: got s=%b%b grant=%b valid=%b want 11 1000 1", s1, s2, grant, sel_valid);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
`ifdef MUXSEQ_LOCK_EN
            if ($urandom_range(0, 7) == 0) lock = ~lock;
`endif
            tick(r, $urandom_range(0, 3) != 0);
            n_cmp++;
            if ({s1, s2, grant, sel_valid, got_done} !== {2'(m_idx), exp_grant(), m_active, want_done}) begin
                n_fail++;
                $display("FAIL random cycle %0d: got s=%b%b grant=%b valid=%b done=%b want s=%b grant=%b valid=%b done=%b",
                         c, s1, s2, grant, sel_valid, got_done, 2'(m_idx), exp_grant(), m_active, want_done);
            end
        end
        lock = 1'b0;
    endtask

`ifdef MUXSEQ_LOCK_EN
    task automatic test_lock();
        do_reset();
        lock = 1'b1;
        tick(4'b0011, 1'b1);
        for (int b = 0; b < 7; b++) begin
            tick(4'b0011, 1'b1);
            n_cmp++;
            if (got_done !== 1'b0 || grant !== 4'b0001) begin
                n_fail++;
                $display("FAIL lock_hold beat %0d: got done=%b grant=%b want 0 0001", b, got_done, grant);
            end
        end
        lock = 1'b0;
        tick(4'b0011, 1'b1);
        n_cmp++;
        if (got_done !== 1'b1 || grant !== 4'b0010 || {s1, s2} !== 2'b01) begin
            n_fail++;
            $display("FAIL lock_release: got done=%b grant=%b s=%b%b want 1 0010 01", got_done, grant, s1, s2);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0; lock = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_early_release();
        test_async_reset();
`ifdef MUXSEQ_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
